// File: rtl/vip_hist_pkg.sv
// vip_hist_pkg: shared FSM states and helpers for the histogram-equalization scheduler
package vip_hist_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    function automatic int scan_len(int bits);
        return 2 ** bits;
    endfunction
    function automatic logic bypass_of(logic enable, logic valid);
        return ~(enable & valid);
    endfunction
endpackage

// File: rtl/vip_hist_lut_arb.sv
// vip_hist_lut_arb: LUT write-port arbiter, pipeline over host, registered output stage
module vip_hist_lut_arb #(
    parameter int BITS = 8
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            busy,
    input  logic            pipe_wr_valid,
    input  logic [BITS-1:0] pipe_wr_addr,
    input  logic [BITS-1:0] pipe_wr_data,
    input  logic            host_req,
    input  logic [BITS-1:0] host_addr,
    input  logic [BITS-1:0] host_data,
    output logic            host_gnt,
    output logic            lut_wren,
    output logic [BITS-1:0] lut_wraddr,
    output logic [BITS-1:0] lut_data
);
    logic wr;
    assign host_gnt = host_req & ~busy & ~pipe_wr_valid;
    assign wr = pipe_wr_valid | host_gnt;
    always_ff @(posedge pclk) begin
        if (rst) begin
            lut_wren   <= 1'b0;
            lut_wraddr <= '0;
            lut_data   <= '0;
        end else begin
            lut_wren <= wr;
            if (wr) begin
                lut_wraddr <= pipe_wr_valid ? pipe_wr_addr : host_addr;
                lut_data   <= pipe_wr_valid ? pipe_wr_data : host_data;
            end
        end
    end
endmodule

// File: rtl/vip_hist_sched.sv
// vip_hist_sched: frame scheduler for histogram bank flip, CDF scan and LUT write control
module vip_hist_sched #(
    parameter int BITS     = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_vsync,
    input  logic            in_href,
    input  logic            cfg_enable,
    input  logic            cfg_freeze,
    output logic            hist_flip,
    output logic            hist_rd_en,
    output logic [BITS-1:0] hist_rd_addr,
    output logic            acc_clr,
    input  logic            pipe_wr_valid,
    input  logic [BITS-1:0] pipe_wr_addr,
    input  logic [BITS-1:0] pipe_wr_data,
    input  logic            host_req,
    input  logic [BITS-1:0] host_addr,
    input  logic [BITS-1:0] host_data,
    output logic            host_gnt,
    output logic            lut_wren,
    output logic [BITS-1:0] lut_wraddr,
    output logic [BITS-1:0] lut_data,
    output logic            bypass,
    output logic            busy,
    output logic            lut_valid,
    output logic            overrun
);
    import vip_hist_pkg::*;
    localparam logic [BITS-1:0] LAST = BITS'(scan_len(BITS) - 1);
    localparam int DW = $clog2(PIPE_LAT + 2);
    localparam logic [DW-1:0] DLAST = DW'(PIPE_LAT);
    state_t state, state_n;
    logic [BITS-1:0] addr, addr_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic vsync_q, vs_rise, go, abort, done;
    assign vs_rise = in_vsync & ~vsync_q;
    assign go = cfg_enable & ~cfg_freeze;
    assign abort = vs_rise & (state != IDLE);
    assign busy = state != IDLE;
    assign hist_rd_en = state == SCAN;
    assign hist_rd_addr = addr;
    always_comb begin
        state_n = state;
        addr_n  = addr;
        dcnt_n  = dcnt;
        done    = 1'b0;
        if (vs_rise) begin
            state_n = go ? SCAN : IDLE;
            addr_n  = '0;
            dcnt_n  = '0;
        end else if (state == SCAN) begin
            state_n = (addr == LAST) ? DRAIN : SCAN;
            addr_n  = (addr == LAST) ? addr : addr + 1'b1;
            dcnt_n  = '0;
        end else if (state == DRAIN) begin
            done    = dcnt == DLAST;
            state_n = done ? IDLE : DRAIN;
            dcnt_n  = dcnt + 1'b1;
        end
    end
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            dcnt      <= '0;
            vsync_q   <= 1'b0;
            hist_flip <= 1'b0;
            acc_clr   <= 1'b0;
            lut_valid <= 1'b0;
            bypass    <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            dcnt      <= dcnt_n;
            vsync_q   <= in_vsync;
            hist_flip <= vs_rise;
            acc_clr   <= vs_rise & (go | abort);
            lut_valid <= abort ? 1'b0 : (done | host_gnt) ? 1'b1 : lut_valid;
            bypass    <= bypass_of(cfg_enable, lut_valid);
            overrun   <= cfg_enable & (overrun | (in_href & busy));
        end
    end
    vip_hist_lut_arb #(.BITS(BITS)) u_arb (
        .pclk          (pclk),
        .rst           (rst),
        .busy          (busy),
        .pipe_wr_valid (pipe_wr_valid),
        .pipe_wr_addr  (pipe_wr_addr),
        .pipe_wr_data  (pipe_wr_data),
        .host_req      (host_req),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_gnt      (host_gnt),
        .lut_wren      (lut_wren),
        .lut_wraddr    (lut_wraddr),
        .lut_data      (lut_data)
    );
endmodule

// File: tb/tb_vip_hist_sched.sv
// tb_vip_hist_sched: scoreboard bench for the histogram-equalization scheduler
module tb_vip_hist_sched;
    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic in_vsync = 1'b0, in_href = 1'b0, cfg_enable = 1'b0, cfg_freeze = 1'b0;
    logic hist_flip, hist_rd_en, acc_clr, host_gnt, lut_wren, bypass, busy, lut_valid, overrun;
    logic [7:0] hist_rd_addr, lut_wraddr, lut_data;
    logic pipe_wr_valid = 1'b0, host_req = 1'b0;
    logic [7:0] pipe_wr_addr = '0, pipe_wr_data = '0, host_addr = '0, host_data = '0;
    int total = 0, bad = 0;
    logic [15:0] wq[$];
    logic [7:0] aq[$];
    logic fq[$];

    always #5 pclk = ~pclk;

    vip_hist_sched #(.BITS(8), .PIPE_LAT(3)) dut (
        .pclk(pclk), .rst(rst), .in_vsync(in_vsync), .in_href(in_href),
        .cfg_enable(cfg_enable), .cfg_freeze(cfg_freeze),
        .hist_flip(hist_flip), .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
        .acc_clr(acc_clr), .pipe_wr_valid(pipe_wr_valid), .pipe_wr_addr(pipe_wr_addr),
        .pipe_wr_data(pipe_wr_data), .host_req(host_req), .host_addr(host_addr),
        .host_data(host_data), .host_gnt(host_gnt), .lut_wren(lut_wren),
        .lut_wraddr(lut_wraddr), .lut_data(lut_data), .bypass(bypass), .busy(busy),
        .lut_valid(lut_valid), .overrun(overrun)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_wren"}, 32'(lut_wren), 0);
        chk({tag, "_rd_en"}, 32'(hist_rd_en), 0);
        chk({tag, "_flip"}, 32'(hist_flip), 0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_lut_valid"}, 32'(lut_valid), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_bypass"}, 32'(bypass), 1);
        chk({tag, "_wraddr"}, 32'(lut_wraddr), 0);
        chk({tag, "_data"}, 32'(lut_data), 0);
        chk({tag, "_rd_addr"}, 32'(hist_rd_addr), 0);
    endtask

    // Monitor: every DUT output event pops and compares against the expected queues
    always @(negedge pclk) begin
        if (lut_wren) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL lut_write_unexpected: got %0h/%0h want none", lut_wraddr, lut_data);
            end else begin
                logic [15:0] e;
                e = wq.pop_front();
                total--;
                chk("lut_write", {16'h0, lut_wraddr, lut_data}, {16'h0, e});
            end
        end
        if (hist_rd_en) begin
            total++;
            if (aq.size() == 0) begin
                bad++;
                $display("FAIL scan_addr_unexpected: got %0h want none", hist_rd_addr);
            end else begin
                logic [7:0] a;
                a = aq.pop_front();
                total--;
                chk("scan_addr", 32'(hist_rd_addr), 32'(a));
            end
        end
        if (hist_flip) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL flip_unexpected: got 1 want 0");
            end else begin
                logic c;
                c = fq.pop_front();
                total--;
                chk("flip_acc_clr", 32'(acc_clr), 32'(c));
            end
        end else if (acc_clr) begin
            total++;
            bad++;
            $display("FAIL acc_clr_without_flip: got 1 want 0");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        step(2);
        check_reset("rst0");
        rst = 1'b0;
        cfg_enable = 1'b1;
        step();
        // Build 1 with href during DRAIN
        in_vsync = 1'b1;
        for (int i = 0; i < 256; i++) aq.push_back(8'(i));
        fq.push_back(1'b1);
        step();
        chk("b1_flip", 32'(hist_flip), 1);
        chk("b1_acc_clr", 32'(acc_clr), 1);
        chk("b1_busy", 32'(busy), 1);
        chk("b1_addr0", 32'(hist_rd_addr), 0);
        in_vsync = 1'b0;
        step(255);
        chk("b1_addr_last", 32'(hist_rd_addr), 255);
        chk("b1_rd_en_last", 32'(hist_rd_en), 1);
        step();
        chk("b1_drain_rd_en", 32'(hist_rd_en), 0);
        chk("b1_drain_busy", 32'(busy), 1);
        in_href = 1'b1;
        step();
        chk("b1_overrun", 32'(overrun), 1);
        in_href = 1'b0;
        step(2);
        chk("b1_t260_busy", 32'(busy), 1);
        chk("b1_t260_valid", 32'(lut_valid), 0);
        step();
        chk("b1_t261_busy", 32'(busy), 0);
        chk("b1_t261_valid", 32'(lut_valid), 1);
        chk("b1_t261_bypass", 32'(bypass), 1);
        step();
        chk("b1_t262_bypass", 32'(bypass), 0);
        chk("b1_overrun_sticky", 32'(overrun), 1);
        // Build 2, aborted at address 100, with host held off throughout
        in_vsync = 1'b1;
        for (int i = 0; i <= 100; i++) aq.push_back(8'(i));
        fq.push_back(1'b1);
        step();
        chk("b2_valid_kept", 32'(lut_valid), 1);
        in_vsync = 1'b0;
        host_req = 1'b1;
        host_addr = 8'h3C;
        host_data = 8'hA5;
        #1;
        chk("b2_gnt_busy", 32'(host_gnt), 0);
        step(100);
        chk("b2_addr100", 32'(hist_rd_addr), 100);
        in_vsync = 1'b1;
        for (int i = 0; i < 256; i++) aq.push_back(8'(i));
        fq.push_back(1'b1);
        step();
        chk("abort_valid", 32'(lut_valid), 0);
        chk("abort_flip", 32'(hist_flip), 1);
        chk("abort_addr0", 32'(hist_rd_addr), 0);
        chk("abort_gnt", 32'(host_gnt), 0);
        in_vsync = 1'b0;
        step(259);
        chk("b2_t260_busy", 32'(busy), 1);
        chk("b2_t260_gnt", 32'(host_gnt), 0);
        step();
        chk("b2_t261_busy", 32'(busy), 0);
        chk("b2_t261_valid", 32'(lut_valid), 1);
        chk("b2_t261_gnt", 32'(host_gnt), 1);
        wq.push_back({8'h3C, 8'hA5});
        step();
        chk("host_wren", 32'(lut_wren), 1);
        chk("host_wraddr", 32'(lut_wraddr), 32'h3C);
        chk("host_data", 32'(lut_data), 32'hA5);
        host_req = 1'b0;
        step();
        // Disabling clears overrun and forces bypass
        cfg_enable = 1'b0;
        step();
        chk("dis_overrun", 32'(overrun), 0);
        chk("dis_bypass", 32'(bypass), 1);
        cfg_enable = 1'b1;
        step(2);
        chk("en_bypass", 32'(bypass), 0);
        // Pipeline and host collide in IDLE
        pipe_wr_valid = 1'b1;
        pipe_wr_addr = 8'h10;
        pipe_wr_data = 8'h20;
        host_req = 1'b1;
        host_addr = 8'h11;
        host_data = 8'h22;
        #1;
        chk("collide_gnt", 32'(host_gnt), 0);
        wq.push_back({8'h10, 8'h20});
        step();
        pipe_wr_valid = 1'b0;
        #1;
        chk("collide_gnt_next", 32'(host_gnt), 1);
        wq.push_back({8'h11, 8'h22});
        step();
        host_req = 1'b0;
        step();
        // Freeze: flip only
        cfg_freeze = 1'b1;
        in_vsync = 1'b1;
        fq.push_back(1'b0);
        step();
        chk("frz_flip", 32'(hist_flip), 1);
        chk("frz_busy", 32'(busy), 0);
        chk("frz_valid", 32'(lut_valid), 1);
        in_vsync = 1'b0;
        step(3);
        chk("frz_rd_en", 32'(hist_rd_en), 0);
        chk("frz_valid_later", 32'(lut_valid), 1);
        cfg_freeze = 1'b0;
        // Reset mid-SCAN
        in_vsync = 1'b1;
        for (int i = 0; i < 10; i++) aq.push_back(8'(i));
        fq.push_back(1'b1);
        step();
        in_vsync = 1'b0;
        step(9);
        chk("rst_scan_addr9", 32'(hist_rd_addr), 9);
        rst = 1'b1;
        step();
        check_reset("rst1");
        rst = 1'b0;
        // Stale pipeline write in IDLE leaves lut_valid alone
        pipe_wr_valid = 1'b1;
        pipe_wr_addr = 8'h77;
        pipe_wr_data = 8'h88;
        wq.push_back({8'h77, 8'h88});
        step();
        pipe_wr_valid = 1'b0;
        chk("stale_wren", 32'(lut_wren), 1);
        step();
        chk("stale_valid", 32'(lut_valid), 0);
        // Host write marks the LUT valid
        host_req = 1'b1;
        host_addr = 8'h5A;
        host_data = 8'hC3;
        #1;
        chk("host_only_gnt", 32'(host_gnt), 1);
        wq.push_back({8'h5A, 8'hC3});
        step();
        host_req = 1'b0;
        chk("host_only_valid", 32'(lut_valid), 1);
        chk("host_only_wren", 32'(lut_wren), 1);
        step();
        chk("host_only_bypass", 32'(bypass), 0);
        step(2);
        chk("wq_drained", 32'(wq.size()), 0);
        chk("aq_drained", 32'(aq.size()), 0);
        chk("fq_drained", 32'(fq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
